// File: rtl/cpu_bus_pkg.sv
// Shared types for the CPU/IO memory bus: arbiter FSM states, port ids and default widths.
package cpu_bus_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic {
        PORT_CPU,
        PORT_IO
    } port_t;

endpackage

// File: rtl/bus_rr_pick.sv
// Two-way round-robin picker: a lone request always wins, a tie goes to the port not served last.
module bus_rr_pick
    import cpu_bus_pkg::*;
(
    input  logic [1:0] req,        // bit 0 = CPU, bit 1 = IO
    input  port_t      last_grant,
    output port_t      grant,
    output logic       grant_vld
);

    always_comb begin
        grant_vld = |req;
        grant     = PORT_CPU;
        if (req[0] && req[1])
            grant = (last_grant == PORT_CPU) ? PORT_IO : PORT_CPU;
        else if (req[1])
            grant = PORT_IO;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates CPU and IO/DMA ports onto a single fixed-latency RAM; one access in flight at a time.
module mem_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_cycle,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t            state;
    port_t             last_grant;
    port_t             pick;
    logic              pick_vld;
    logic [3:0]        cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    bus_rr_pick u_pick (
        .req        ({io_req, cpu_req}),
        .last_grant (last_grant),
        .grant      (pick),
        .grant_vld  (pick_vld)
    );

    // last_grant doubles as the id of the port whose access is in flight.
    always_ff @(posedge clk or posedge reset_cycle) begin
        if (reset_cycle) begin
            state      <= IDLE;
            last_grant <= PORT_IO;
            cnt        <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata      <= '0;
            cpu_ack    <= 1'b0;
            io_ack     <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            io_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state      <= ACCESS;
                        cnt        <= CNT_INIT;
                        last_grant <= pick;
                        if (pick == PORT_CPU) begin
                            we_q    <= cpu_we;
                            addr_q  <= cpu_addr;
                            wdata_q <= cpu_wdata;
                        end else begin
                            we_q    <= io_we;
                            addr_q  <= io_addr;
                            wdata_q <= io_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        if (!we_q)
                            rdata <= ram_rdata;
                        state   <= RESP;
                        cpu_ack <= (last_grant == PORT_CPU);
                        io_ack  <= (last_grant == PORT_IO);
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ram_en    = (state == ACCESS);
    assign ram_we    = ram_en && we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: LATENCY=2 instance against a small RAM model, plus a LATENCY=1 instance for spacing.
module tb_mem_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset_cycle = 1'b1;
    logic       cpu_req = 0, cpu_we = 0, io_req = 0, io_we = 0;
    logic [7:0] cpu_addr = 0, cpu_wdata = 0, io_addr = 0, io_wdata = 0;
    logic       cpu_ack, io_ack, ram_en, ram_we, busy;
    logic [7:0] rdata, ram_addr, ram_wdata, ram_rdata;

    logic       cpu_req1 = 0;
    logic [7:0] cpu_addr1 = 0;
    logic       cpu_ack1, io_ack1, ram_en1, ram_we1, busy1;
    logic [7:0] rdata1, ram_addr1, ram_wdata1, ram_rdata1;

    logic [7:0] mem [256];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .LATENCY(2)) dut (
        .clk(clk), .reset_cycle(reset_cycle),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata), .io_ack(io_ack),
        .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .LATENCY(1)) dut1 (
        .clk(clk), .reset_cycle(reset_cycle),
        .cpu_req(cpu_req1), .cpu_we(1'b0), .cpu_addr(cpu_addr1), .cpu_wdata(8'h00), .cpu_ack(cpu_ack1),
        .io_req(1'b0), .io_we(1'b0), .io_addr(8'h00), .io_wdata(8'h00), .io_ack(io_ack1),
        .rdata(rdata1), .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1),
        .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1), .busy(busy1)
    );

    assign ram_rdata  = mem[ram_addr];
    assign ram_rdata1 = ram_addr1 ^ 8'hFF;

    always @(posedge clk)
        if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        int cpu_at[$];
        int io_at[$];
        int overlap;
        int ack_cnt;
        int en_cnt;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'hA5;

        // reset values
        #12;
        chk("rst_ram_en", 32'(ram_en), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_ram_addr", 32'(ram_addr), 32'h0);
        chk("rst_acks", 32'({cpu_ack, io_ack, ram_we}), 32'h0);
        @(negedge clk) reset_cycle = 0;

        // CPU read 0x10
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        @(negedge clk);
        chk("rd_c1_en", 32'({ram_en, ram_we, busy}), 32'h5);
        chk("rd_c1_addr", 32'(ram_addr), 32'h10);
        chk("rd_c1_ack", 32'(cpu_ack), 32'h0);
        @(negedge clk);
        chk("rd_c2_en", 32'(ram_en), 32'h1);
        chk("rd_c2_addr", 32'(ram_addr), 32'h10);
        chk("rd_c2_ack", 32'(cpu_ack), 32'h0);
        @(negedge clk);
        chk("rd_resp_ack", 32'({cpu_ack, io_ack}), 32'h2);
        chk("rd_resp_en", 32'(ram_en), 32'h0);
        chk("rd_rdata", 32'(rdata), 32'hA5);
        cpu_req = 0;
        @(negedge clk);
        chk("rd_idle", 32'({cpu_ack, busy}), 32'h0);

        // IO write 0x20 <- 0x3C
        io_req = 1; io_we = 1; io_addr = 8'h20; io_wdata = 8'h3C;
        @(negedge clk);
        chk("wr_c1_we", 32'({ram_en, ram_we}), 32'h3);
        chk("wr_c1_addr", 32'({ram_addr, ram_wdata}), 32'h203C);
        @(negedge clk);
        chk("wr_c2_we", 32'({ram_en, ram_we}), 32'h3);
        @(negedge clk);
        chk("wr_resp_ack", 32'({cpu_ack, io_ack}), 32'h1);
        chk("wr_resp_we", 32'(ram_we), 32'h0);
        chk("wr_rdata_kept", 32'(rdata), 32'hA5);
        chk("wr_mem", 32'(mem[8'h20]), 32'h3C);
        io_req = 0; io_we = 0;
        @(negedge clk);
        chk("wr_ack_gone", 32'(io_ack), 32'h0);

        // address change after grant must not disturb the access
        cpu_req = 1; cpu_addr = 8'h10;
        @(negedge clk);
        cpu_addr = 8'h55;
        chk("hold_c1_addr", 32'(ram_addr), 32'h10);
        @(negedge clk);
        chk("hold_c2_addr", 32'(ram_addr), 32'h10);
        @(negedge clk);
        chk("hold_ack", 32'(cpu_ack), 32'h1);
        chk("hold_rdata", 32'(rdata), 32'hA5);
        cpu_req = 0; cpu_addr = 8'h10;
        @(negedge clk);

        // both ports requesting from reset
        reset_cycle = 1;
        cpu_req = 1; cpu_addr = 8'h10;
        io_req = 1; io_we = 0; io_addr = 8'h20;
        @(negedge clk) reset_cycle = 0;
        overlap = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (cpu_ack && io_ack) overlap++;
            if (cpu_ack) begin
                cpu_at.push_back(i);
                chk("rr_cpu_rdata", 32'(rdata), 32'hA5);
            end
            if (io_ack) begin
                io_at.push_back(i);
                chk("rr_io_rdata", 32'(rdata), 32'h3C);
            end
        end
        cpu_req = 0; io_req = 0;
        chk("rr_overlap", 32'(overlap), 32'h0);
        chk("rr_n_cpu", 32'(cpu_at.size()), 32'd2);
        chk("rr_n_io", 32'(io_at.size()), 32'd2);
        if (cpu_at.size() == 2 && io_at.size() == 2) begin
            chk("rr_cpu0", 32'(cpu_at[0]), 32'd3);
            chk("rr_io0", 32'(io_at[0]), 32'd7);
            chk("rr_cpu1", 32'(cpu_at[1]), 32'd11);
            chk("rr_io1", 32'(io_at[1]), 32'd15);
        end
        @(negedge clk);
        @(negedge clk);

        // reset during second ACCESS cycle
        cpu_req = 1; cpu_addr = 8'h10;
        @(negedge clk);
        chk("abort_c1_en", 32'(ram_en), 32'h1);
        @(posedge clk);
        #2 reset_cycle = 1;
        #1;
        chk("abort_en", 32'({ram_en, busy, cpu_ack}), 32'h0);
        chk("abort_rdata", 32'(rdata), 32'h0);
        cpu_req = 0;
        @(negedge clk) reset_cycle = 0;
        ack_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (cpu_ack || io_ack) ack_cnt++;
        end
        chk("abort_no_ack", 32'(ack_cnt), 32'h0);
        cpu_req = 1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("abort_retry_ack", 32'(cpu_ack), 32'h1);
        chk("abort_retry_rdata", 32'(rdata), 32'hA5);
        cpu_req = 0;
        @(negedge clk);

        // LATENCY=1, back-to-back CPU reads
        cpu_req1 = 1; cpu_addr1 = 8'h33;
        ack_cnt = 0; en_cnt = 0;
        cpu_at.delete();
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (ram_en1) en_cnt++;
            if (io_ack1) ack_cnt++;
            if (cpu_ack1) begin
                cpu_at.push_back(i);
                chk("l1_rdata", 32'(rdata1), 32'hCC);
            end
        end
        cpu_req1 = 0;
        chk("l1_en_cycles", 32'(en_cnt), 32'd4);
        chk("l1_io_ack", 32'(ack_cnt), 32'd0);
        chk("l1_n_ack", 32'(cpu_at.size()), 32'd4);
        for (int k = 0; k < cpu_at.size() && k < 4; k++)
            chk("l1_ack_at", 32'(cpu_at[k]), 32'(2 + 3 * k));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, RAM address width.
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 Parameter LATENCY, default 2, RAM access cycles (legal range 1..15).
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 reset_cycle  input  1  asynchronous, active-high reset.
REQ-006 cpu_req  input  1  CPU (fetch/immediate/stack) access request, level.
REQ-007 cpu_we  input  1  CPU write enable, qualified by cpu_req.
REQ-008 cpu_addr  input  ADDR_W  CPU address.
REQ-009 cpu_wdata  input  DATA_W  CPU write data.
REQ-010 cpu_ack  output  1  one-cycle completion pulse to CPU; drives controller bus_ready.
REQ-011 io_req, io_we, io_addr, io_wdata  input  1/1/ADDR_W/DATA_W  IO/DMA port, same meaning as CPU port.
REQ-012 io_ack  output  1  one-cycle completion pulse to IO port.
REQ-013 rdata  output  DATA_W  read data returned to the acknowledged requester.
REQ-014 ram_en, ram_we  output  1/1  RAM strobe and write enable.
REQ-015 ram_addr, ram_wdata  output  ADDR_W/DATA_W  RAM address and write data.
REQ-016 ram_rdata  input  DATA_W  RAM read data, valid in last access cycle.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, ACCESS, RESP; all outputs registered or decoded from state only.
REQ-019 IDLE: no request -> stay; any request -> latch winner's addr/we/wdata, load latency counter with LATENCY-1, go ACCESS.
REQ-020 Arbitration: round-robin over two ports; on simultaneous requests, grant the port not served last; single request always granted.
REQ-021 last_grant updates on every grant.
REQ-022 ACCESS: ram_en=1, ram_addr/ram_wdata/ram_we from latched values, held constant for exactly LATENCY cycles; counter decrements each cycle.
REQ-023 Counter==0 in ACCESS: capture ram_rdata into rdata (reads only; writes leave rdata unchanged), go RESP.
REQ-024 RESP: assert ack of granted port only, for exactly one cycle; ram_en=0; next state IDLE unconditionally.
REQ-025 Latency: request sampled at edge N -> ack high during cycle N+LATENCY+1; minimum spacing between successive acks is LATENCY+2 cycles.
REQ-026 Requester holds req/addr/we/wdata stable until it sees ack and drops req the edge after; inputs changing after grant do not affect the access in flight.
REQ-027 Request arriving while busy waits; no request is lost or reordered within a port.
REQ-028 cpu_ack and io_ack never high together; ram_we never high outside ACCESS.
REQ-029 Counter width 4 bits; no wrap: LATENCY=1 gives exactly one ACCESS cycle.

Reset
REQ-030 reset_cycle asserts immediately: state=IDLE, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, rdata=0, cpu_ack=0, io_ack=0, busy=0, counter=0.
REQ-031 last_grant resets to IO so CPU wins first simultaneous request.
REQ-032 Reset mid-ACCESS or mid-RESP abandons the access with no ack; requester re-requests after reset.

Structure
REQ-033 Shared package cpu_bus_pkg holds the state enum (IDLE, ACCESS, RESP), port-id typedef (PORT_CPU, PORT_IO), and default ADDR_W/DATA_W.
REQ-034 One sub-module bus_rr_pick: combinational two-way round-robin picker (req vector + last_grant -> grant id, grant valid).

Verification
REQ-035 LATENCY=2, cpu_req read addr 0x10, RAM holds 0xA5 -> ram_en high 2 cycles with ram_addr=0x10, cpu_ack pulse 3 cycles after request, rdata=0xA5.
REQ-036 io_req write addr 0x20 data 0x3C -> ram_we high 2 cycles, addr 0x20, wdata 0x3C, io_ack single pulse, rdata unchanged.
REQ-037 cpu_req and io_req both held high from reset -> grant order CPU, IO, CPU, IO; acks never overlap; acks 4 cycles apart.
REQ-038 cpu_addr changed to 0x55 one cycle after grant of 0x10 -> ram_addr stays 0x10 for whole access.
REQ-039 reset_cycle pulsed during second ACCESS cycle -> ram_en drops same cycle, no ack, FSM in IDLE, next request served normally.
REQ-040 LATENCY=1 sweep with back-to-back CPU requests -> one ACCESS cycle each, acks every 3 cycles.
